mips_multicycle_control: RTL

Moore-style main controller for the multicycle MIPS datapath (Data_Path). It decodes the instruction register's opcode/funct fields and sequences the datapath through fetch, decode, execute, memory and write-back states, driving every datapath control strobe. It replaces the hand-sequenced stimulus now used to exercise Data_Path. It also counts retired instructions and flags unsupported encodings.

---
 rtl/mips_multicycle_control_if.sv | 29 ++
 rtl/mips_multicycle_control.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control_if.sv
// Control/status bundle between the multicycle MIPS controller (master) and Data_Path (slave).
interface mips_multicycle_control_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCen;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       PCsrc;

    modport master (
        input  Opcode, Funct, Zero,
        output PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCsrc
    );

    modport slave (
        output Opcode, Funct, Zero,
        input  PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCsrc
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore main controller for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/write-back, counts retired instructions and flags unsupported encodings.
module mips_multicycle_control #(
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    mips_multicycle_control_if.master ctrl,
    output logic [3:0]                State_o,
    output logic                      Illegal_o,
    output logic [WIDTH-1:0]          Instr_count_o
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] instr_count;
    logic [2:0]       funct_alu;
    logic             funct_ok;
    logic             decode_illegal;
    logic             retire;

    always_comb begin
        funct_alu = ALU_ADD;
        funct_ok  = 1'b1;
        case (ctrl.Funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    // Opcode/Funct are held by the IR outside FETCH, so decoding them directly is safe.
    always_comb begin
        next_state     = FETCH;
        decode_illegal = 1'b0;
        case (state)
            FETCH:   next_state = DECODE;
            DECODE: begin
                case (ctrl.Opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_RTYPE: begin
                        if (funct_ok) next_state = EXECUTE;
                        else          decode_illegal = 1'b1;
                    end
                    default:      decode_illegal = 1'b1;
                endcase
            end
            MEMADR:  next_state = (ctrl.Opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   next_state = MEMWB;
            EXECUTE: next_state = ALUWB;
            ADDIEX:  next_state = ADDIWB;
            default: next_state = FETCH;
        endcase
    end

    assign retire = (state == MEMWB) || (state == MEMWR) || (state == ALUWB) ||
                    (state == BRANCH) || (state == ADDIWB);

    // Outputs are forced low while reset is held so no write strobe can leak out.
    always_comb begin
        ctrl.PCen       = 1'b0;
        ctrl.IorD       = 1'b0;
        ctrl.MemWrite   = 1'b0;
        ctrl.IRWrite    = 1'b0;
        ctrl.RegDst     = 1'b0;
        ctrl.MemtoReg   = 1'b0;
        ctrl.RegWrite   = 1'b0;
        ctrl.ALUSrcA    = 1'b0;
        ctrl.ALUSrcB    = 2'b00;
        ctrl.ALUControl = 3'b000;
        ctrl.PCsrc      = 1'b0;
        State_o         = 4'd0;
        Illegal_o       = 1'b0;
        if (!reset) begin
            State_o   = state;
            Illegal_o = decode_illegal;
            case (state)
                FETCH: begin
                    ctrl.IRWrite    = 1'b1;
                    ctrl.ALUSrcB    = 2'b01;
                    ctrl.ALUControl = ALU_ADD;
                    ctrl.PCen       = 1'b1;
                end
                DECODE: begin
                    ctrl.ALUSrcB    = 2'b11;
                    ctrl.ALUControl = ALU_ADD;
                end
                MEMADR, ADDIEX: begin
                    ctrl.ALUSrcA    = 1'b1;
                    ctrl.ALUSrcB    = 2'b10;
                    ctrl.ALUControl = ALU_ADD;
                end
                MEMRD:  ctrl.IorD = 1'b1;
                MEMWB: begin
                    ctrl.MemtoReg = 1'b1;
                    ctrl.RegWrite = 1'b1;
                end
                MEMWR: begin
                    ctrl.IorD     = 1'b1;
                    ctrl.MemWrite = 1'b1;
                end
                EXECUTE: begin
                    ctrl.ALUSrcA    = 1'b1;
                    ctrl.ALUControl = funct_alu;
                end
                ALUWB: begin
                    ctrl.RegDst   = 1'b1;
                    ctrl.RegWrite = 1'b1;
                end
                BRANCH: begin
                    ctrl.ALUSrcA    = 1'b1;
                    ctrl.ALUControl = ALU_SUB;
                    ctrl.PCsrc      = 1'b1;
                    ctrl.PCen       = ctrl.Zero;
                end
                ADDIWB: ctrl.RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (retire) instr_count <= instr_count + WIDTH'(1);
        end
    end

    assign Instr_count_o = instr_count;

endmodule
